// File: rtl/p405s_icu_regicu_seq.sv
// Sequencer for the ICU enable-gated address register: arbitrates debug,
// cache-op and fetch loads and walks a critical-word-first line fill.
module p405s_icu_regicu_seq #(
    parameter int WIDTH      = 32,
    parameter int FILL_BEATS = 4,
    parameter int BEAT_BYTES = 4
) (
    input  logic             CB,
    input  logic             resetCore,
    input  logic             dbgReq,
    input  logic [WIDTH-1:0] dbgAddr,
    output logic             dbgGnt,
    input  logic             copReq,
    input  logic [WIDTH-1:0] copAddr,
    output logic             copGnt,
    input  logic             fetchReq,
    input  logic [WIDTH-1:0] fetchAddr,
    output logic             fetchGnt,
    input  logic             fillStart,
    input  logic             fillBeatAck,
    input  logic             fillAbort,
    input  logic [WIDTH-1:0] regL2,
    output logic [WIDTH-1:0] regD,
    output logic             regE1,
    output logic             fillActive,
    output logic [2:0]       fillBeatCnt,
    output logic             fillDone
);
    localparam int BB = $clog2(BEAT_BYTES);
    // Beat-index field of the address; adding one beat and masking wraps the
    // field without carrying into the line address above it.
    localparam logic [WIDTH-1:0] FLD_MASK = WIDTH'(FILL_BEATS - 1) << BB;
    localparam logic [WIDTH-1:0] BEAT_INC = WIDTH'(BEAT_BYTES);
    localparam logic [2:0]       LAST_BEAT = 3'(FILL_BEATS - 1);

    typedef enum logic {IDLE, FILL} state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    logic       rr_fetch_q, rr_fetch_d;   // 1: fetch won last, 0: cop won last
    logic [WIDTH-1:0] bumped;

    assign bumped = (regL2 & ~FLD_MASK) | ((regL2 + BEAT_INC) & FLD_MASK);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        rr_fetch_d = rr_fetch_q;
        dbgGnt     = 1'b0;
        copGnt     = 1'b0;
        fetchGnt   = 1'b0;
        regE1      = 1'b0;
        regD       = '0;
        if (!resetCore) begin
            case (state_q)
                IDLE: begin
                    if (fillStart) begin
                        state_d = FILL;
                        cnt_d   = 3'd0;
                    end else if (dbgReq) begin
                        dbgGnt = 1'b1;
                        regE1  = 1'b1;
                        regD   = dbgAddr;
                    end else if (fetchReq && (!copReq || !rr_fetch_q)) begin
                        fetchGnt   = 1'b1;
                        regE1      = 1'b1;
                        regD       = fetchAddr;
                        rr_fetch_d = 1'b1;
                    end else if (copReq) begin
                        copGnt     = 1'b1;
                        regE1      = 1'b1;
                        regD       = copAddr;
                        rr_fetch_d = 1'b0;
                    end
                end
                FILL: begin
                    if (fillAbort) begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                    end else if (fillBeatAck) begin
                        regE1 = 1'b1;
                        regD  = bumped;
                        if (cnt_q == LAST_BEAT) begin
                            state_d = IDLE;
                            cnt_d   = 3'd0;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CB) begin
        if (resetCore) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            done_q     <= 1'b0;
            rr_fetch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            rr_fetch_q <= rr_fetch_d;
        end
    end

    assign fillActive  = (state_q == FILL);
    assign fillBeatCnt = cnt_q;
    assign fillDone    = done_q;
endmodule

// File: doc/p405s_icu_regicu_seq.md
Name: p405s_icu_regICU_seq

Overview:
- Controller for the ICU 32-bit enable-gated address register (D/E1/L2 register clocked by CB).
- Shares the register between three requesters: debug, cache-op and fetch.
- Sequences a critical-word-first line-fill walk that steps the register through every word of a cache line.
- Drives the register's D and E1 inputs and reads its L2 output back for the fill increment.

Parameters:
- WIDTH, 32, address/register width; bit 0 is the MSB, bit WIDTH-1 is the LSB.
- FILL_BEATS, 4, beats per line fill; power of 2, range 2..8.
- BEAT_BYTES, 4, bytes per beat; power of 2.

Ports:
- CB  in  1  clock.
- resetCore  in  1  synchronous reset, active-high.
- dbgReq  in  1  debug load request.
- dbgAddr  in  WIDTH  debug load value.
- dbgGnt  out  1  debug load granted.
- copReq  in  1  cache-op load request.
- copAddr  in  WIDTH  cache-op load value.
- copGnt  out  1  cache-op load granted.
- fetchReq  in  1  fetch load request.
- fetchAddr  in  WIDTH  fetch load value.
- fetchGnt  out  1  fetch load granted.
- fillStart  in  1  begin a line fill from the current register value.
- fillBeatAck  in  1  one fill beat accepted by the bus.
- fillAbort  in  1  terminate the fill.
- regL2  in  WIDTH  register output feedback.
- regD  out  WIDTH  register D input.
- regE1  out  1  register load enable.
- fillActive  out  1  fill in progress.
- fillBeatCnt  out  3  beats completed in the current fill.
- fillDone  out  1  one-cycle pulse when a fill completes.

Behaviour:
- Interface: one clock, CB. resetCore is synchronous and active-high.
- States: IDLE, FILL. Register writes take effect at the CB edge where regE1=1.
- Reset (resetCore=1 at a CB edge):
  - state=IDLE, fillBeatCnt=0, fillDone=0, rrLast=COP (fetch favoured next).
  - While resetCore=1: all grants=0 and regE1=0.
  - Reset mid-fill abandons the fill with no fillDone pulse.
- IDLE, fillStart=1:
  - Go to FILL, fillBeatCnt=0.
  - No grants, regE1=0; fillStart beats all requesters.
- IDLE, no fillStart, arbitration is combinational; same-cycle grant, and the register loads at that edge:
  - dbgReq has fixed top priority.
  - fetch vs cop is round-robin on rrLast. If both request, grant the one not equal to rrLast. rrLast updates to the granted one (dbg grants leave rrLast unchanged).
  - A single requester is granted immediately regardless of rrLast.
  - At most one grant is high. When a grant is high, regE1=1 and regD = the winner's addr. Otherwise regE1=0 and regD=0.
- FILL:
  - All grants=0; requests stall (requesters hold req).
  - fillActive=1 (state==FILL, registered).
  - Increment field: the LB=log2(FILL_BEATS) bits ending at bit WIDTH-1-log2(BEAT_BYTES). Defaults give bits [28:29].
  - fillBeatAck=1 and fillAbort=0: regE1=1. regD=regL2 with the field +1 mod FILL_BEATS; bits outside the field are unchanged, so there is no carry out of the field. fillBeatCnt increments.
  - On the ack with fillBeatCnt==FILL_BEATS-1:
    - The register wraps back to the critical-word address.
    - The next cycle has state=IDLE, fillBeatCnt=0 and fillDone=1 for exactly one cycle.
  - fillAbort=1 (with or without ack): no write; next state IDLE, fillBeatCnt=0, no fillDone.
  - fillStart while in FILL: ignored.
- fillDone is registered. It is 0 in every other cycle.
- New requests are arbitrable in the same cycle fillDone is high.

Test Plan:
- Reset, then fetchReq=1, fetchAddr=0x0000_1000 -> fetchGnt=1, regE1=1 same cycle; regL2=0x0000_1000 next cycle.
- dbgReq, copReq and fetchReq all high for 3 cycles, with dbgReq dropped after cycle 1 -> grants dbg, fetch, cop. Both rrLast toggles are checked.
- regL2=0x0000_2008, fillStart, 4 acks on consecutive cycles:
  - regD sequence is 0x200C, 0x2000, 0x2004, 0x2008.
  - fillBeatCnt steps 1,2,3 then reads 0 with fillDone=1 on the following cycle; fillActive drops the same cycle.
- Fill with regL2=0xFFFF_FFFC: first ack gives regD=0xFFFF_FFF0; upper bits are unchanged (no carry).
- Fill with ack and fillAbort together after 2 beats -> no write that cycle, IDLE next cycle, fillDone stays 0. fetchReq held throughout is granted only after return to IDLE.
- resetCore during beat 2 of a fill -> next cycle IDLE, fillBeatCnt=0, regE1=0 during reset, no fillDone. fillStart and fetchReq together in IDLE -> FILL entered, fetchGnt=0.
